// File: rtl/hms_timer.sv
// hms_timer: HH:MM:SS BCD timer with an internal tick prescaler, up/down
// counting, validated parallel preset and one-cycle status pulses.
//
// Ports:
//   clk, reset (sync, active-low)   clock and reset
//   en, up, load                    run enable, direction, preset strobe
//   ld_su..ld_ht                    BCD preset digits
//   seconds_*/minutes_*/hours_*     BCD digit outputs
//   step, wrap, done, load_err      registered one-cycle status pulses
//   zero                            high while every digit is 0
module hms_timer #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned HOURS_MOD = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] ld_su,
  input  logic [2:0] ld_st,
  input  logic [3:0] ld_mu,
  input  logic [2:0] ld_mt,
  input  logic [3:0] ld_hu,
  input  logic [3:0] ld_ht,
  output logic [3:0] seconds_units,
  output logic [2:0] seconds_tens,
  output logic [3:0] minutes_units,
  output logic [2:0] minutes_tens,
  output logic [3:0] hours_units,
  output logic [3:0] hours_tens,
  output logic       step,
  output logic       wrap,
  output logic       done,
  output logic       zero,
  output logic       load_err
);

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] HMAX_T  = 4'((HOURS_MOD - 1) / 10);
  localparam logic [3:0] HMAX_U  = 4'((HOURS_MOD - 1) % 10);
  localparam logic [7:0] HMOD8   = 8'(HOURS_MOD);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0] su_q, su_d, mu_q, mu_d, hu_q, hu_d, ht_q, ht_d;
  logic [2:0] st_q, st_d, mt_q, mt_d;
  logic step_q, step_d, wrap_q, wrap_d, done_q, done_d, err_q, err_d;

  logic       tick_w, zero_w, one_w, h_max_w, all_max_w, ld_ok_w;
  logic [7:0] ld_h_w;

  always_comb begin
    tick_w    = en && (presc_q == PMAX);
    zero_w    = (su_q == '0) && (st_q == '0) && (mu_q == '0) &&
                (mt_q == '0) && (hu_q == '0) && (ht_q == '0);
    one_w     = (su_q == 4'd1) && (st_q == '0) && (mu_q == '0) &&
                (mt_q == '0) && (hu_q == '0) && (ht_q == '0);
    h_max_w   = (ht_q == HMAX_T) && (hu_q == HMAX_U);
    all_max_w = h_max_w && (su_q == 4'd9) && (st_q == 3'd5) &&
                (mu_q == 4'd9) && (mt_q == 3'd5);
    ld_h_w    = {4'd0, ld_ht} * 8'd10 + {4'd0, ld_hu};
    ld_ok_w   = (ld_su <= 4'd9) && (ld_st <= 3'd5) && (ld_mu <= 4'd9) &&
                (ld_mt <= 3'd5) && (ld_hu <= 4'd9) && (ld_ht <= 4'd9) &&
                (ld_h_w < HMOD8);

    presc_d = presc_q;
    su_d = su_q; st_d = st_q; mu_d = mu_q; mt_d = mt_q; hu_d = hu_q; ht_d = ht_q;
    step_d = 1'b0; wrap_d = 1'b0; done_d = 1'b0; err_d = 1'b0;

    // Any load, valid or not, takes the cycle: no prescaler advance, no step.
    if (load) begin
      if (ld_ok_w) begin
        su_d = ld_su; st_d = ld_st; mu_d = ld_mu;
        mt_d = ld_mt; hu_d = ld_hu; ht_d = ld_ht;
        presc_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (en) begin
      presc_d = tick_w ? '0 : presc_q + 1'b1;
      if (tick_w && up) begin
        step_d = 1'b1;
        wrap_d = all_max_w;
        if (su_q != 4'd9) su_d = su_q + 4'd1;
        else begin
          su_d = '0;
          if (st_q != 3'd5) st_d = st_q + 3'd1;
          else begin
            st_d = '0;
            if (mu_q != 4'd9) mu_d = mu_q + 4'd1;
            else begin
              mu_d = '0;
              if (mt_q != 3'd5) mt_d = mt_q + 3'd1;
              else begin
                mt_d = '0;
                if (h_max_w) begin
                  hu_d = '0; ht_d = '0;
                end else if (hu_q != 4'd9) hu_d = hu_q + 4'd1;
                else begin
                  hu_d = '0; ht_d = ht_q + 4'd1;
                end
              end
            end
          end
        end
      end else if (tick_w && !zero_w) begin
        // Down count stops at 00:00:00; a tick there is silently absorbed.
        step_d = 1'b1;
        done_d = one_w;
        if (su_q != '0) su_d = su_q - 4'd1;
        else begin
          su_d = 4'd9;
          if (st_q != '0) st_d = st_q - 3'd1;
          else begin
            st_d = 3'd5;
            if (mu_q != '0) mu_d = mu_q - 4'd1;
            else begin
              mu_d = 4'd9;
              if (mt_q != '0) mt_d = mt_q - 3'd1;
              else begin
                mt_d = 3'd5;
                if (hu_q == '0 && ht_q == '0) begin
                  hu_d = HMAX_U; ht_d = HMAX_T;
                end else if (hu_q != '0) hu_d = hu_q - 4'd1;
                else begin
                  hu_d = 4'd9; ht_d = ht_q - 4'd1;
                end
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q <= '0;
      su_q <= '0; st_q <= '0; mu_q <= '0; mt_q <= '0; hu_q <= '0; ht_q <= '0;
      step_q <= 1'b0; wrap_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      su_q <= su_d; st_q <= st_d; mu_q <= mu_d; mt_q <= mt_d; hu_q <= hu_d; ht_q <= ht_d;
      step_q <= step_d; wrap_q <= wrap_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign seconds_units = su_q;
  assign seconds_tens  = st_q;
  assign minutes_units = mu_q;
  assign minutes_tens  = mt_q;
  assign hours_units   = hu_q;
  assign hours_tens    = ht_q;
  assign step          = step_q;
  assign wrap          = wrap_q;
  assign done          = done_q;
  assign load_err      = err_q;
  assign zero          = zero_w;

endmodule

// File: tb/tb_hms_timer.sv
// tb_hms_timer: directed bench for hms_timer with a scoreboard queue.
// Instance A: TICK_DIV=4, HOURS_MOD=24. Instance B: TICK_DIV=1, HOURS_MOD=12.
// Observed word = {time digits (22 bits), step, wrap, done, zero, load_err}.
module tb_hms_timer;

  typedef struct {
    logic       en, up, load;
    logic [3:0] su, mu, hu, ht;
    logic [2:0] st, mt;
  } drv_t;

  typedef struct {
    bit          b;
    string       tag;
    logic [26:0] exp;
  } sb_t;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] S = 5'b10000;
  localparam logic [4:0] Z = 5'b00010;
  localparam logic [4:0] W = 5'b11010;
  localparam logic [4:0] D = 5'b10110;
  localparam logic [4:0] E = 5'b00001;

  logic clk, reset;
  drv_t da, db;
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] a_su, a_mu, a_hu, a_ht, b_su, b_mu, b_hu, b_ht;
  logic [2:0] a_st, a_mt, b_st, b_mt;
  logic a_step, a_wrap, a_done, a_zero, a_err;
  logic b_step, b_wrap, b_done, b_zero, b_err;
  logic [26:0] obs_a, obs_b;

  assign obs_a = {a_ht, a_hu, a_mt, a_mu, a_st, a_su, a_step, a_wrap, a_done, a_zero, a_err};
  assign obs_b = {b_ht, b_hu, b_mt, b_mu, b_st, b_su, b_step, b_wrap, b_done, b_zero, b_err};

  hms_timer #(.TICK_DIV(4), .HOURS_MOD(24)) dut_a (
    .clk(clk), .reset(reset), .en(da.en), .up(da.up), .load(da.load),
    .ld_su(da.su), .ld_st(da.st), .ld_mu(da.mu), .ld_mt(da.mt), .ld_hu(da.hu), .ld_ht(da.ht),
    .seconds_units(a_su), .seconds_tens(a_st), .minutes_units(a_mu), .minutes_tens(a_mt),
    .hours_units(a_hu), .hours_tens(a_ht), .step(a_step), .wrap(a_wrap), .done(a_done),
    .zero(a_zero), .load_err(a_err));

  hms_timer #(.TICK_DIV(1), .HOURS_MOD(12)) dut_b (
    .clk(clk), .reset(reset), .en(db.en), .up(db.up), .load(db.load),
    .ld_su(db.su), .ld_st(db.st), .ld_mu(db.mu), .ld_mt(db.mt), .ld_hu(db.hu), .ld_ht(db.ht),
    .seconds_units(b_su), .seconds_tens(b_st), .minutes_units(b_mu), .minutes_tens(b_mt),
    .hours_units(b_hu), .hours_tens(b_ht), .step(b_step), .wrap(b_wrap), .done(b_done),
    .zero(b_zero), .load_err(b_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] ev(input int h, input int m, input int s, input logic [4:0] f);
    return {4'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), f};
  endfunction

  task automatic push(input bit b, input string tag, input int h, input int m, input int s,
                      input logic [4:0] f);
    sb_t it;
    it.b = b; it.tag = tag; it.exp = ev(h, m, s, f);
    sbq.push_back(it);
  endtask

  // Advance one edge, then drain the scoreboard against the settled outputs.
  task automatic tick();
    sb_t it;
    logic [26:0] obs;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      it  = sbq.pop_front();
      obs = it.b ? obs_b : obs_a;
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic cyc(input bit b, input string tag, input int h, input int m, input int s,
                     input logic [4:0] f);
    push(b, tag, h, m, s, f);
    tick();
  endtask

  task automatic setld(input bit b, input int h, input int m, input int s);
    if (b) begin
      db.ht = 4'(h / 10); db.hu = 4'(h % 10); db.mt = 3'(m / 10);
      db.mu = 4'(m % 10); db.st = 3'(s / 10); db.su = 4'(s % 10);
    end else begin
      da.ht = 4'(h / 10); da.hu = 4'(h % 10); da.mt = 3'(m / 10);
      da.mu = 4'(m % 10); da.st = 3'(s / 10); da.su = 4'(s % 10);
    end
  endtask

  initial begin
    reset = 1'b0;
    da = '{en: 1'b0, up: 1'b0, load: 1'b0, su: '0, mu: '0, hu: '0, ht: '0, st: '0, mt: '0};
    db = da;

    for (int i = 0; i < 2; i++) begin
      push(0, "rst_a", 0, 0, 0, Z);
      push(1, "rst_b", 0, 0, 0, Z);
      tick();
    end

    // Instance A: prescaler timing, pause/resume, wrap, load vs step, reset.
    reset = 1'b1; da.en = 1'b1; da.up = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, "pre_step_a", 0, 0, 0, Z);
    cyc(0, "step1_a", 0, 0, 1, S);
    da.en = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, "pause_a", 0, 0, 1, N);
    da.en = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, "resume_a", 0, 0, 1, N);
    cyc(0, "step2_a", 0, 0, 2, S);

    setld(0, 23, 59, 59); da.load = 1'b1;
    cyc(0, "ld_max_a", 23, 59, 59, N);
    da.load = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, "pre_wrap_a", 23, 59, 59, N);
    cyc(0, "wrap_a", 0, 0, 0, W);
    for (int i = 0; i < 3; i++) cyc(0, "post_wrap_a", 0, 0, 0, Z);
    cyc(0, "after_wrap_a", 0, 0, 1, S);

    for (int i = 0; i < 3; i++) cyc(0, "hold_a", 0, 0, 1, N);
    setld(0, 5, 30, 0); da.load = 1'b1;
    cyc(0, "ld_vs_step_a", 5, 30, 0, N);
    da.load = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, "post_ld_a", 5, 30, 0, N);
    cyc(0, "after_ld_a", 5, 30, 1, S);

    da.load = 1'b1; reset = 1'b0;
    cyc(0, "mid_rst_a", 0, 0, 0, Z);
    reset = 1'b1; da.load = 1'b0; da.en = 1'b0;

    // Instance B: down counting, done, load validation, HOURS_MOD=12 wrap.
    db.en = 1'b1; db.up = 1'b0;
    setld(1, 1, 0, 0); db.load = 1'b1;
    cyc(1, "ld_b", 1, 0, 0, N);
    db.load = 1'b0;
    cyc(1, "dn1_b", 0, 59, 59, S);
    cyc(1, "dn2_b", 0, 59, 58, S);
    setld(1, 10, 0, 0); db.load = 1'b1;
    cyc(1, "ld10_b", 10, 0, 0, N);
    db.load = 1'b0;
    cyc(1, "hr_borrow_b", 9, 59, 59, S);
    setld(1, 0, 0, 1); db.load = 1'b1;
    cyc(1, "ld1_b", 0, 0, 1, N);
    db.load = 1'b0;
    cyc(1, "done_b", 0, 0, 0, D);
    for (int i = 0; i < 2; i++) cyc(1, "hold0_b", 0, 0, 0, Z);

    db.en = 1'b0;
    setld(1, 11, 59, 59); db.load = 1'b1;
    cyc(1, "ld_1159_b", 11, 59, 59, N);
    setld(1, 12, 0, 0);
    cyc(1, "bad_hours_b", 11, 59, 59, E);
    setld(1, 0, 0, 0); db.st = 3'd6;
    cyc(1, "bad_st_b", 11, 59, 59, E);
    setld(1, 0, 0, 0); db.hu = 4'd10;
    cyc(1, "bad_hu_b", 11, 59, 59, E);
    db.load = 1'b0;
    cyc(1, "err_clear_b", 11, 59, 59, N);
    db.en = 1'b1; db.up = 1'b1;
    cyc(1, "wrap_b", 0, 0, 0, W);
    cyc(1, "wrap_next_b", 0, 0, 1, S);
    db.up = 1'b0;
    cyc(1, "dir_change_b", 0, 0, 0, D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
